// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the 5-stage core: register enables and bubble strobes
// for load-use hazards, taken branches and multi-cycle data-memory accesses.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_enable,
    output logic             ifid_enable,
    output logic             idex_enable,
    output logic             exmem_enable,
    output logic             memwb_enable,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout,
    output logic             state
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam int              WC_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    logic [0:0]       r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0] r_stall_count;
    logic             r_mem_timeout;

    logic             w_lu;
    logic             w_ms;
    logic [0:0]       w_next_state;
    logic [WC_W-1:0]  w_next_wait;
    logic             w_freeze;
    logic [4:0]       w_en;
    logic [1:0]       w_fl;

    assign w_lu = ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    assign w_ms = mem_req && !mem_ready;

    // w_en = {pc, ifid, idex, exmem, memwb}, w_fl = {ifid, idex}.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        w_en         = 5'b00000;
        w_fl         = 2'b00;
        w_next_state = r_state;
        w_next_wait  = r_wait_cnt;
        w_freeze     = 1'b0;
        if (reset) begin
            w_next_state = ST_RUN;
            w_next_wait  = '0;
        end else if (r_state == ST_RUN && w_ms) begin
            w_freeze     = 1'b1;
            w_next_state = ST_MEM_WAIT;
            w_next_wait  = WC_W'(1);
        end else if (r_state == ST_MEM_WAIT && !mem_ready) begin
            w_freeze    = 1'b1;
            w_next_wait = (r_wait_cnt >= WC_MAX) ? WC_MAX : r_wait_cnt + WC_W'(1);
        end else begin
            // Release cycle or plain RUN: branch outranks load-use since the
            // hazarding ID instruction is flushed anyway.
            w_next_state = ST_RUN;
            w_next_wait  = '0;
            if (branch_taken) begin
                w_en = 5'b11111;
                w_fl = 2'b11;
            end else if (w_lu) begin
                w_en = 5'b00111;
                w_fl = 2'b01;
            end else begin
                w_en = 5'b11111;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
            if (!w_en[4] && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + CNT_W'(1);
            if (w_freeze && (MEM_TIMEOUT > 0) && (w_next_wait == WC_MAX))
                r_mem_timeout <= 1'b1;
        end
    end

    assign pc_enable    = w_en[4];
    assign ifid_enable  = w_en[3];
    assign idex_enable  = w_en[2];
    assign exmem_enable = w_en[1];
    assign memwb_enable = w_en[0];
    assign ifid_flush   = w_fl[1];
    assign idex_flush   = w_fl[0];
    assign stall_count  = r_stall_count;
    assign mem_timeout  = r_mem_timeout;
    assign state        = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expectations are queued as each step
// is driven and popped when the outputs are sampled.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 5;
    localparam int MEM_TIMEOUT = 15;
    localparam int SC_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0] en;
        logic [1:0] fl;
        logic       st;
        logic       to;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             id_uses_rs, id_uses_rt, ex_mem_read;
    logic             branch_taken, mem_req, mem_ready;
    logic             pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable;
    logic             ifid_flush, idex_flush;
    logic [CNT_W-1:0] stall_count;
    logic             mem_timeout;
    logic             state;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_sc  = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_enable(pc_enable), .ifid_enable(ifid_enable), .idex_enable(idex_enable),
        .exmem_enable(exmem_enable), .memwb_enable(memwb_enable),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .stall_count(stall_count), .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_in();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_mem_read = 1; ex_rd = rd; id_rs = rd; id_uses_rs = 1;
    endtask

    // Inputs are already driven; checks comb outputs at negedge, registers after the edge.
    task automatic step(input string tag, input logic [4:0] en, input logic [1:0] fl,
                        input logic st, input logic to);
        exp_t e;
        sb.push_back('{en: en, fl: fl, st: st, to: to});
        if (!en[4] && m_sc != SC_MAX) m_sc++;
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ":en"}, 32'({pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable}), 32'(e.en));
        chk({tag, ":fl"}, 32'({ifid_flush, idex_flush}), 32'(e.fl));
        @(posedge clk);
        #1;
        chk({tag, ":state"}, 32'(state), 32'(e.st));
        chk({tag, ":timeout"}, 32'(mem_timeout), 32'(e.to));
        chk({tag, ":stall_count"}, 32'(stall_count), 32'(m_sc));
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        #3;
        chk("reset:en", 32'({pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable}), 32'd0);
        chk("reset:fl", 32'({ifid_flush, idex_flush}), 32'd0);
        chk("reset:regs", 32'({state, mem_timeout, stall_count}), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        step("idle", 5'b11111, 2'b00, 0, 0);

        set_lu(5'd5);
        step("lu_rs", 5'b00111, 2'b01, 0, 0);
        set_lu(5'd0);
        step("lu_rd0", 5'b11111, 2'b00, 0, 0);

        clear_in();
        ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 1; id_rs = 3; id_uses_rs = 1;
        step("lu_rt", 5'b00111, 2'b01, 0, 0);
        id_uses_rt = 0;
        step("lu_rt_unused", 5'b11111, 2'b00, 0, 0);

        clear_in();
        branch_taken = 1;
        step("branch", 5'b11111, 2'b11, 0, 0);
        set_lu(5'd9);
        step("branch_lu", 5'b11111, 2'b11, 0, 0);

        clear_in();
        mem_req = 1;
        for (int i = 0; i < 4; i++) step("memwait", 5'b00000, 2'b00, 1, 0);
        mem_ready = 1;
        step("mem_release", 5'b11111, 2'b00, 0, 0);

        clear_in();
        mem_req = 1; branch_taken = 1;
        for (int i = 0; i < 3; i++) step("mem_branch_freeze", 5'b00000, 2'b00, 1, 0);
        mem_ready = 1;
        step("mem_branch_release", 5'b11111, 2'b11, 0, 0);

        clear_in();
        mem_req = 1; set_lu(5'd4);
        step("mem_lu_freeze", 5'b00000, 2'b00, 1, 0);
        mem_ready = 1;
        step("mem_lu_release", 5'b00111, 2'b01, 0, 0);

        clear_in();
        mem_req = 1;
        for (int i = 1; i <= 20; i++)
            step($sformatf("timeout_%0d", i), 5'b00000, 2'b00, 1, (i >= MEM_TIMEOUT));
        mem_ready = 1;
        step("timeout_release", 5'b11111, 2'b00, 0, 1);

        clear_in();
        set_lu(5'd12);
        step("stall_saturate", 5'b00111, 2'b01, 0, 1);

        clear_in();
        mem_req = 1;
        step("pre_async", 5'b00000, 2'b00, 1, 1);
        #2 reset = 1'b1;
        #1;
        m_sc = 0;
        chk("async:en", 32'({pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable}), 32'd0);
        chk("async:fl", 32'({ifid_flush, idex_flush}), 32'd0);
        chk("async:state", 32'(state), 32'd0);
        chk("async:stall_count", 32'(stall_count), 32'd0);
        chk("async:timeout", 32'(mem_timeout), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_in();
        step("post_reset", 5'b11111, 2'b00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
